// File: rtl/arb_pkg.sv
// Shared types and sizes for the round-robin decoder arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/decoder2x4.sv
// 2-to-4 one-hot decoder used to turn the winner index into grant lines.
module decoder2x4
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   i,
  output logic [NUM_REQ-1:0] d
);

  // one-hot decode of the index
  always_comb begin
    d    = '0;
    d[i] = 1'b1;
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Four-client round-robin arbiter with a per-grant tenure limit and a
// mandatory idle cycle between any two grants.
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests (also the guard cycle)
// GRANT | one client owns the resource; tenure counter running
module rr_decoder_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   idx_d;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_d;
  logic               release_c;
  logic [NUM_REQ-1:0] dec_out;

  // round-robin scan: lowest offset from last winner wins; later loop
  // iterations overwrite earlier ones, so scan from the far end inward
  always_comb begin
    winner = last_q + IDX_W'(1);
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last_q + IDX_W'(k);
      if (req[cand]) winner = cand;
    end
  end

  assign release_c = done | ~req[gnt_idx] | (cnt_q == CNT_W'(MAX_HOLD));

  // next-state logic; release always lands in IDLE, which forms the guard cycle
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = gnt_idx;
    cnt_d   = cnt_q;
    busy_d  = busy;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = winner;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          last_d  = gnt_idx;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  decoder2x4 u_dec (
    .i (idx_d),
    .d (dec_out)
  );

  // register state, pointer, tenure counter and the gated one-hot grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 2'b11;
      cnt_q   <= '0;
      gnt_idx <= '0;
      busy    <= 1'b0;
      gnt     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_idx <= idx_d;
      busy    <= busy_d;
      gnt     <= dec_out & {NUM_REQ{busy_d}};
    end
  end

  // grant lines never carry more than one client
  always @(posedge clk) begin
    if (rst_n) assert ($onehot0(gnt));
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter with hand-computed expectations.
module tb_rr_decoder_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;

  int errors = 0;
  int checks = 0;

  rr_decoder_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] order [5];

  initial begin
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;

    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #2;
    chk("reset_gnt", {4'b0, gnt}, 8'h00);
    chk("reset_idx", {6'b0, gnt_idx}, 8'h00);
    chk("reset_busy", {7'b0, busy}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_noreq_gnt", {4'b0, gnt}, 8'h00);

    // single requester: 8-cycle tenure, forced release, guard, re-grant
    req = 4'b0001;
    tick();
    chk("t1_first_gnt", {4'b0, gnt}, 8'h01);
    chk("t1_first_busy", {7'b0, busy}, 8'h01);
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk($sformatf("t1_hold_c%0d", c), {4'b0, gnt}, 8'h01);
    end
    tick();
    chk("t1_guard_gnt", {4'b0, gnt}, 8'h00);
    chk("t1_guard_busy", {7'b0, busy}, 8'h00);
    tick();
    chk("t1_regrant", {4'b0, gnt}, 8'h01);
    req = 4'b0000;
    tick();
    chk("t1_release", {4'b0, gnt}, 8'h00);

    // pointer back to 3 so client 0 leads the rotation
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;

    // all request, done in second grant cycle
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk($sformatf("t2_g%0d_c1", g), {4'b0, gnt}, {4'b0, order[g]});
      tick();
      chk($sformatf("t2_g%0d_c2", g), {4'b0, gnt}, {4'b0, order[g]});
      done = 1'b1;
      tick();
      chk($sformatf("t2_g%0d_guard", g), {4'b0, gnt}, 8'h00);
      done = 1'b0;
    end

    // wrap-around: after client 2, 0101 must go to client 0
    req = 4'b0100;
    tick();
    chk("t3_gnt2", {4'b0, gnt}, 8'h04);
    done = 1'b1;
    tick();
    chk("t3_rel", {4'b0, gnt}, 8'h00);
    done = 1'b0;
    req  = 4'b0101;
    tick();
    chk("t3_wrap_gnt", {4'b0, gnt}, 8'h01);
    chk("t3_wrap_idx", {6'b0, gnt_idx}, 8'h00);
    req = 4'b0000;
    tick();
    chk("t3_end", {4'b0, gnt}, 8'h00);

    // client 3 requests during client 1's grant, then client 1 drops
    req = 4'b0010;
    tick();
    chk("t4_gnt1", {4'b0, gnt}, 8'h02);
    req = 4'b1010;
    tick();
    chk("t4_ignore3", {4'b0, gnt}, 8'h02);
    req = 4'b1000;
    tick();
    chk("t4_rel", {4'b0, gnt}, 8'h00);
    chk("t4_rel_idx", {6'b0, gnt_idx}, 8'h01);
    tick();
    chk("t4_gnt3", {4'b0, gnt}, 8'h08);
    chk("t4_idx3", {6'b0, gnt_idx}, 8'h03);
    req = 4'b0000;
    tick();
    chk("t4_end", {4'b0, gnt}, 8'h00);

    // asynchronous reset in the middle of a grant to client 2
    req = 4'b0100;
    tick();
    tick();
    tick();
    chk("t5_pre_gnt", {4'b0, gnt}, 8'h04);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_async_gnt", {4'b0, gnt}, 8'h00);
    chk("t5_async_busy", {7'b0, busy}, 8'h00);
    chk("t5_async_idx", {6'b0, gnt_idx}, 8'h00);
    #2 rst_n = 1'b1;
    tick();
    chk("t5_after_gnt", {4'b0, gnt}, 8'h04);

    // done and request drop together: one release, stays idle
    done = 1'b1;
    req  = 4'b0000;
    tick();
    done = 1'b0;
    chk("t6_rel_gnt", {4'b0, gnt}, 8'h00);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t6_idle_gnt%0d", c), {4'b0, gnt}, 8'h00);
      chk($sformatf("t6_idle_busy%0d", c), {7'b0, busy}, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
